// File: rtl/spe_accumulate_fire.sv
`default_nettype none
// ============================================================================
// Module      : spe_accumulate_fire
// Description : Summing PE for the NoC convolution array. It accumulates
//               NUM_PARTIALS partial-sum packets for one output neuron and
//               adds the total to that neuron's stored membrane potential.
//               The saturated result is compared against THRESHOLD and one
//               spike packet is emitted toward the output memory.
//
// Ports       : clk        - single clock, rising-edge
//               rst_n      - synchronous active-low reset
//               in_valid   - upstream packet valid
//               in_ready   - SPE can accept a packet this cycle
//               in_packet  - [29:26] dest addr, [25] opcode, [24:0] data
//               out_valid  - spike packet valid
//               out_ready  - downstream accepts the spike packet
//               out_packet - [29:26] OUT_ADDR, [25]=1, [7:1] slot, [0] spike
//               clear_mem  - request to zero all membranes and restart slots
//               addr_err   - sticky: accepted packet had a foreign address
// Revision    : 1.0 - initial release
// ============================================================================
module spe_accumulate_fire #(
    parameter int MY_ADDR      = 0,
    parameter int OUT_ADDR     = 11,
    parameter int NUM_PARTIALS = 5,
    parameter int NUM_SLOTS    = 89,
    parameter int THRESHOLD    = 64,
    parameter int SUM_WIDTH    = 14,
    parameter int ACC_WIDTH    = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] in_packet,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] out_packet,
    input  logic        clear_mem,
    output logic        addr_err
);

    localparam int c_SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int c_CNT_W  = $clog2(NUM_PARTIALS + 1);

    localparam logic [1:0] c_ST_ACCUM   = 2'd0;
    localparam logic [1:0] c_ST_COMPUTE = 2'd1;
    localparam logic [1:0] c_ST_SEND    = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] c_THRESH  = ACC_WIDTH'(THRESHOLD);
    localparam logic [c_CNT_W-1:0]          c_LAST_CNT = c_CNT_W'(NUM_PARTIALS - 1);
    localparam logic [c_SLOT_W-1:0]         c_LAST_SLOT = c_SLOT_W'(NUM_SLOTS - 1);

    logic [1:0]                  r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_SLOT_W-1:0]         r_slot;
    logic                        r_clear_pend;
    logic                        r_out_valid;
    logic [29:0]                 r_out_packet;
    logic                        r_addr_err;
    logic signed [ACC_WIDTH-1:0] r_mem [NUM_SLOTS];

    logic                        w_clear_act;
    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_addr_ok;
    logic signed [ACC_WIDTH-1:0] w_partial;
    logic signed [ACC_WIDTH-1:0] w_mem_rd;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic signed [ACC_WIDTH-1:0] w_v;
    logic                        w_spike;
    logic [29:0]                 w_pkt;
    logic                        w_unused_bits;

    // The clear only starts on a neuron boundary so an in-flight neuron
    // always completes against the membranes it started with.
    assign w_clear_act = (r_state == c_ST_ACCUM) && (r_cnt == '0) && r_clear_pend;
    assign w_in_ready  = rst_n && (r_state == c_ST_ACCUM) && !w_clear_act;
    assign w_accept    = in_valid && w_in_ready;
    assign w_addr_ok   = (in_packet[29:26] == 4'(MY_ADDR));
    assign w_partial   = {{(ACC_WIDTH-SUM_WIDTH){in_packet[SUM_WIDTH-1]}},
                          in_packet[SUM_WIDTH-1:0]};
    assign w_unused_bits = ^in_packet[25:SUM_WIDTH];

    assign w_mem_rd = r_mem[r_slot];
    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign w_sum = {r_acc[ACC_WIDTH-1], r_acc} + {w_mem_rd[ACC_WIDTH-1], w_mem_rd};

    always_comb begin
        w_v = w_sum[ACC_WIDTH-1:0];
        if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
            w_v = w_sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
        end
    end

    assign w_spike = (w_v >= c_THRESH);

    always_comb begin
        w_pkt        = '0;
        w_pkt[29:26] = 4'(OUT_ADDR);
        w_pkt[25]    = 1'b1;
        w_pkt[7:1]   = 7'(r_slot);
        w_pkt[0]     = w_spike;
    end

    // Membrane storage is deliberately outside reset; a new image is
    // started with clear_mem.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clear_act) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_mem[i] <= '0;
                end
            end else if (r_state == c_ST_COMPUTE) begin
                r_mem[r_slot] <= w_spike ? '0 : w_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_ACCUM;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_slot       <= '0;
            r_clear_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
            r_addr_err   <= 1'b0;
        end else begin
            if (w_clear_act) begin
                r_slot       <= '0;
                r_clear_pend <= 1'b0;
            end
            // A new request always wins over the completion of the old one.
            if (clear_mem) begin
                r_clear_pend <= 1'b1;
            end

            case (r_state)
                c_ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_addr_ok) begin
                            r_acc <= r_acc + w_partial;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == c_LAST_CNT) begin
                                r_state <= c_ST_COMPUTE;
                            end
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    r_out_packet <= w_pkt;
                    r_out_valid  <= 1'b1;
                    r_state      <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_slot      <= (r_slot == c_LAST_SLOT) ? '0 : r_slot + 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= c_ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= c_ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_packet = r_out_packet;
    assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_spe_accumulate_fire.sv
`default_nettype none
// ============================================================================
// Module      : tb_spe_accumulate_fire
// Description : Self-checking bench for spe_accumulate_fire. A behavioural
//               model (integer membranes, slot pointer, running sum) predicts
//               every spike packet; directed and randomized neurons are run
//               through the DUT and compared with immediate assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spe_accumulate_fire;

    localparam int NS     = 89;
    localparam int NP     = 5;
    localparam int THR    = 64;
    localparam int SATMAX = 131071;
    localparam int SATMIN = -131072;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_packet;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_packet;
    logic        clear_mem;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    int          m_mem [NS];
    int          m_slot;
    int          m_acc;
    int          m_cnt;
    logic        m_addr_err;
    logic [29:0] exp_q [$];

    always #5 clk = ~clk;

    spe_accumulate_fire dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_packet  (in_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .clear_mem  (clear_mem),
        .addr_err   (addr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] spike_pkt(input int slot, input logic spike);
        logic [29:0] p;
        p = '0;
        p[29:26] = 4'd11;
        p[25]    = 1'b1;
        p[7:1]   = 7'(slot);
        p[0]     = spike;
        return p;
    endfunction

    // Neuron completion: membrane + sum, clamp, threshold, store.
    task automatic model_fire();
        int   v;
        logic spike;
        v = m_acc + m_mem[m_slot];
        if (v > SATMAX) v = SATMAX;
        if (v < SATMIN) v = SATMIN;
        spike = (v >= THR);
        m_mem[m_slot] = spike ? 0 : v;
        exp_q.push_back(spike_pkt(m_slot, spike));
        m_acc = 0;
        m_cnt = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) m_mem[i] = 0;
        m_slot = 0;
    endtask

    task automatic push(input logic [3:0] addr, input int data);
        logic        ok;
        logic [13:0] d14;
        logic [10:0] junk;
        ok   = 1'b0;
        d14  = data[13:0];
        junk = 11'($urandom());
        in_packet = {addr, 1'($urandom()), junk, d14};
        in_valid  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("push_accepted", {31'b0, ok}, 32'd1);
        if (ok) begin
            if (addr == 4'd0) begin
                m_acc += data;
                m_cnt++;
                if (m_cnt == NP) model_fire();
            end else begin
                m_addr_err = 1'b1;
            end
        end
    endtask

    task automatic collect(input int hold);
        int          w;
        logic [29:0] exp;
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 30'bx;
        check("out_packet", {2'b0, out_packet}, {2'b0, exp});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_packet", {2'b0, out_packet}, {2'b0, exp});
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_slot = (m_slot == NS - 1) ? 0 : m_slot + 1;
    endtask

    task automatic neuron_const(input int val);
        for (int i = 0; i < NP; i++) push(4'd0, val);
        collect(0);
    endtask

    task automatic neuron_rand(input int lo, input int hi);
        for (int i = 0; i < NP; i++) push(4'd0, lo + int'($urandom_range(hi - lo, 0)));
        collect(0);
    endtask

    // Clear issued while idle: one cycle with in_ready low, then ready again.
    task automatic do_clear();
        clear_mem = 1'b1;
        @(posedge clk); #1;
        clear_mem = 1'b0;
        check("clear_busy_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("clear_done_in_ready", {31'b0, in_ready}, 32'd1);
        model_clear();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_packet = '0;
        out_ready = 1'b0; clear_mem = 1'b0;
        m_slot = 0; m_acc = 0; m_cnt = 0; m_addr_err = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_packet", {2'b0, out_packet}, 32'd0);
        check("rst_addr_err", {31'b0, addr_err}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        do_clear();

        // First neuron, sum 64 exactly at threshold; latency checks.
        push(4'd0, 10); push(4'd0, 20); push(4'd0, 5); push(4'd0, 15); push(4'd0, 14);
        check("compute_no_valid", {31'b0, out_valid}, 32'd0);
        check("compute_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("latency_valid", {31'b0, out_valid}, 32'd1);
        check("first_pkt_const", {2'b0, out_packet}, 32'h2E000001);
        collect(0);

        // Slot 1 stores 40 without firing.
        neuron_const(8);

        // Foreign address mid-accumulation is dropped.
        push(4'd0, 3); push(4'd0, 4);
        push(4'd3, 1000);
        check("addr_err_set", {31'b0, addr_err}, {31'b0, m_addr_err});
        push(4'd0, 5); push(4'd0, 6); push(4'd0, 7);
        collect(0);
        check("addr_err_sticky", {31'b0, addr_err}, 32'd1);

        // Backpressure: hold 10 cycles in SEND.
        for (int i = 0; i < NP; i++) push(4'd0, int'($urandom_range(40, 0)) - 20);
        collect(10);

        // Random neurons up to the wrap from slot 88 back to 0.
        while (m_slot != 0) neuron_rand(-300, 300);
        neuron_rand(-20, -10);
        // Slot 1 still holds 40: 40 + 25 = 65 fires.
        check("slot1_before_fire", m_slot, 1);
        neuron_const(5);
        check("slot1_fire_pkt", {2'b0, out_packet}, {2'b0, spike_pkt(1, 1'b1)});

        // Clear arriving after the 2nd partial of the current neuron.
        push(4'd0, 30); push(4'd0, 30);
        clear_mem = 1'b1;
        @(posedge clk); #1;
        clear_mem = 1'b0;
        push(4'd0, 30); push(4'd0, 30); push(4'd0, 30);
        collect(0);
        check("midclear_busy", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("midclear_ready", {31'b0, in_ready}, 32'd1);
        model_clear();

        // Negative partials: -15 stored at slot 0, later 80 added gives 65.
        neuron_const(-3);
        while (m_slot != 0) neuron_rand(-100, 100);
        neuron_const(16);

        // Negative saturation then recovery over eight wraps of memory.
        do_clear();
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < NS; s++) neuron_const(-8192);
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < NS; s++) neuron_const(8191);

        // Reset while in SEND abandons the packet and the count.
        for (int i = 0; i < NP; i++) push(4'd0, 1);
        @(posedge clk); #1;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_send_valid", {31'b0, out_valid}, 32'd0);
        check("rst_send_addr_err", {31'b0, addr_err}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        m_acc = 0; m_cnt = 0; m_addr_err = 1'b0;
        do_clear();
        for (int i = 0; i < NP - 1; i++) push(4'd0, 20);
        repeat (3) @(posedge clk);
        #1;
        check("cnt_restart_no_valid", {31'b0, out_valid}, 32'd0);
        push(4'd0, 20);
        collect(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
